// File: rtl/multicycle_control.sv
// multicycle_control
//   Control FSM for the multicycle RV32I datapath under TopDE. It sequences
//   fetch, decode, execute, memory and writeback. Every datapath strobe and
//   mux select is decoded from the registered state, plus iMemReady and the
//   ALU flags where needed.
//
// Parameters
//   RESET_HALT  1 = come out of reset in HALT (debug bring-up), 0 = FETCH.
//
// Ports
//   clock, reset          rising-edge clock, async active-high reset
//   iOpcode/iFunct3/iFunct7b5  instruction fields from IR
//   iZero/iLt/iLtu        ALU flags used for branch decisions
//   iMemReady             shared I/D memory finishes the request this cycle
//   oMemReq/oMemWrite/oIorD  memory request, store, address select
//   oIRWrite/oPCWrite/oPCSource  IR/OldPC latch, PC load, PC source
//   oRegWrite/oWBSel      register file write and writeback select
//   oALUSrcA/oALUSrcB/oALUOp  ALU operand selects and operation class
//   oHalt                 FSM parked in HALT
//   oCycleCount/oInstret  performance counters (see below)
//
// Build option
//   MC_PERF_COUNTERS_EN   when defined, oCycleCount counts non-HALT cycles and
//                         oInstret counts returns to FETCH. When it is not
//                         defined, both ports are tied to 0.
module multicycle_control #(
    parameter bit RESET_HALT = 1'b0
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [6:0]  iOpcode,
    input  logic [2:0]  iFunct3,
    input  logic        iFunct7b5,
    input  logic        iZero,
    input  logic        iLt,
    input  logic        iLtu,
    input  logic        iMemReady,
    output logic        oMemReq,
    output logic        oMemWrite,
    output logic        oIorD,
    output logic        oIRWrite,
    output logic        oPCWrite,
    output logic        oPCSource,
    output logic        oRegWrite,
    output logic [1:0]  oWBSel,
    output logic [1:0]  oALUSrcA,
    output logic [1:0]  oALUSrcB,
    output logic [1:0]  oALUOp,
    output logic        oHalt,
    output logic [63:0] oCycleCount,
    output logic [63:0] oInstret
);

    localparam logic [3:0] S_FETCH      = 4'd0;
    localparam logic [3:0] S_DECODE     = 4'd1;
    localparam logic [3:0] S_EXEC_R     = 4'd2;
    localparam logic [3:0] S_EXEC_I     = 4'd3;
    localparam logic [3:0] S_EXEC_LUI   = 4'd4;
    localparam logic [3:0] S_EXEC_AUIPC = 4'd5;
    localparam logic [3:0] S_WB_ALU     = 4'd6;
    localparam logic [3:0] S_ADDR       = 4'd7;
    localparam logic [3:0] S_MEM_RD     = 4'd8;
    localparam logic [3:0] S_WB_MEM     = 4'd9;
    localparam logic [3:0] S_MEM_WR     = 4'd10;
    localparam logic [3:0] S_BRANCH     = 4'd11;
    localparam logic [3:0] S_JAL        = 4'd12;
    localparam logic [3:0] S_JALR       = 4'd13;
    localparam logic [3:0] S_HALT       = 4'd14;

    logic [3:0] state, next_state;
    logic       taken, br_ok;
    logic       mem_req, mem_write, iord, ir_write, pc_write, pc_source, reg_write, halt;
    logic [1:0] wb_sel, src_a, src_b, alu_op;

    // funct7 is consumed by the ALU control decoder, not by the sequencer.
    logic unused_funct7;
    assign unused_funct7 = iFunct7b5;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) state <= RESET_HALT ? S_HALT : S_FETCH;
        else       state <= next_state;
    end

    // Branch condition. funct3 010/011 are not valid branches.
    always_comb begin
        taken = 1'b0;
        br_ok = 1'b1;
        case (iFunct3)
            3'b000:  taken = iZero;
            3'b001:  taken = ~iZero;
            3'b100:  taken = iLt;
            3'b101:  taken = ~iLt;
            3'b110:  taken = iLtu;
            3'b111:  taken = ~iLtu;
            default: br_ok = 1'b0;
        endcase
    end

    always_comb begin
        next_state = state;
        mem_req = 1'b0; mem_write = 1'b0; iord = 1'b0; ir_write = 1'b0;
        pc_write = 1'b0; pc_source = 1'b0; reg_write = 1'b0; halt = 1'b0;
        wb_sel = 2'd0; src_a = 2'd0; src_b = 2'd0; alu_op = 2'd0;
        case (state)
            S_FETCH: begin
                // PC+4 computed while the instruction is fetched.
                mem_req = 1'b1; src_b = 2'd1;
                ir_write = iMemReady; pc_write = iMemReady;
                if (iMemReady) next_state = S_DECODE;
            end
            S_DECODE: begin
                // OldPC + imm precomputes the branch/JAL target into ALUOut.
                src_a = 2'd1; src_b = 2'd2;
                case (iOpcode)
                    7'b0110011:            next_state = S_EXEC_R;
                    7'b0010011:            next_state = S_EXEC_I;
                    7'b0000011, 7'b0100011: next_state = S_ADDR;
                    7'b1100011:            next_state = S_BRANCH;
                    7'b1101111:            next_state = S_JAL;
                    7'b1100111:            next_state = S_JALR;
                    7'b0110111:            next_state = S_EXEC_LUI;
                    7'b0010111:            next_state = S_EXEC_AUIPC;
                    default:               next_state = S_HALT;
                endcase
            end
            S_EXEC_R:     begin src_a = 2'd2; src_b = 2'd0; alu_op = 2'd2; next_state = S_WB_ALU; end
            S_EXEC_I:     begin src_a = 2'd2; src_b = 2'd2; alu_op = 2'd2; next_state = S_WB_ALU; end
            S_EXEC_LUI:   begin src_a = 2'd3; src_b = 2'd2; next_state = S_WB_ALU; end
            S_EXEC_AUIPC: begin src_a = 2'd1; src_b = 2'd2; next_state = S_WB_ALU; end
            S_WB_ALU:     begin reg_write = 1'b1; next_state = S_FETCH; end
            S_ADDR: begin
                src_a = 2'd2; src_b = 2'd2;
                // IR still holds the instruction, so the opcode picks load vs store.
                next_state = (iOpcode == 7'b0000011) ? S_MEM_RD : S_MEM_WR;
            end
            S_MEM_RD: begin
                mem_req = 1'b1; iord = 1'b1;
                if (iMemReady) next_state = S_WB_MEM;
            end
            S_WB_MEM: begin reg_write = 1'b1; wb_sel = 2'd1; next_state = S_FETCH; end
            S_MEM_WR: begin
                mem_req = 1'b1; mem_write = 1'b1; iord = 1'b1;
                if (iMemReady) next_state = S_FETCH;
            end
            S_BRANCH: begin
                src_a = 2'd2; src_b = 2'd0; alu_op = 2'd1; pc_source = 1'b1;
                pc_write = taken & br_ok;
                next_state = br_ok ? S_FETCH : S_HALT;
            end
            S_JAL: begin
                reg_write = 1'b1; wb_sel = 2'd2; pc_write = 1'b1; pc_source = 1'b1;
                next_state = S_FETCH;
            end
            S_JALR: begin
                // The datapath clears bit 0 of rs1+imm before it loads PC.
                src_a = 2'd2; src_b = 2'd2; pc_write = 1'b1;
                reg_write = 1'b1; wb_sel = 2'd2;
                next_state = S_FETCH;
            end
            S_HALT:  halt = 1'b1;
            default: next_state = S_HALT;
        endcase
    end

    // The reset state is still decoded while reset is high. Gate the outputs
    // so that nothing reaches the datapath until reset is released.
    assign oMemReq   = mem_req   & ~reset;
    assign oMemWrite = mem_write & ~reset;
    assign oIorD     = iord      & ~reset;
    assign oIRWrite  = ir_write  & ~reset;
    assign oPCWrite  = pc_write  & ~reset;
    assign oPCSource = pc_source & ~reset;
    assign oRegWrite = reg_write & ~reset;
    assign oHalt     = halt      & ~reset;
    assign oWBSel    = reset ? 2'd0 : wb_sel;
    assign oALUSrcA  = reset ? 2'd0 : src_a;
    assign oALUSrcB  = reset ? 2'd0 : src_b;
    assign oALUOp    = reset ? 2'd0 : alu_op;

`ifdef MC_PERF_COUNTERS_EN
    logic [63:0] cycle_q, instret_q;
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            cycle_q   <= 64'd0;
            instret_q <= 64'd0;
        end else begin
            if (state != S_HALT) cycle_q <= cycle_q + 64'd1;
            // A return to FETCH from any other state retires one instruction.
            if (next_state == S_FETCH && state != S_FETCH) instret_q <= instret_q + 64'd1;
        end
    end
    assign oCycleCount = cycle_q;
    assign oInstret    = instret_q;
`else
    assign oCycleCount = 64'd0;
    assign oInstret    = 64'd0;
`endif

endmodule

// File: tb/tb_multicycle_control.sv
module tb_multicycle_control;

    logic        clock = 1'b0;
    logic        reset;
    logic [6:0]  iOpcode;
    logic [2:0]  iFunct3;
    logic        iFunct7b5, iZero, iLt, iLtu, iMemReady;
    logic        oMemReq, oMemWrite, oIorD, oIRWrite, oPCWrite, oPCSource, oRegWrite, oHalt;
    logic [1:0]  oWBSel, oALUSrcA, oALUSrcB, oALUOp;
    logic [63:0] oCycleCount, oInstret;

    multicycle_control dut (
        .clock(clock), .reset(reset), .iOpcode(iOpcode), .iFunct3(iFunct3),
        .iFunct7b5(iFunct7b5), .iZero(iZero), .iLt(iLt), .iLtu(iLtu),
        .iMemReady(iMemReady), .oMemReq(oMemReq), .oMemWrite(oMemWrite),
        .oIorD(oIorD), .oIRWrite(oIRWrite), .oPCWrite(oPCWrite),
        .oPCSource(oPCSource), .oRegWrite(oRegWrite), .oWBSel(oWBSel),
        .oALUSrcA(oALUSrcA), .oALUSrcB(oALUSrcB), .oALUOp(oALUOp),
        .oHalt(oHalt), .oCycleCount(oCycleCount), .oInstret(oInstret)
    );

    always #5 clock = ~clock;

    int tests = 0;
    int fails = 0;

    // Output bundle: {req, wr, iord, irw, pcw, pcs, rw, wb[2], srca[2], srcb[2], aluop[2], halt}
    logic [15:0] dut_o;
    assign dut_o = {oMemReq, oMemWrite, oIorD, oIRWrite, oPCWrite, oPCSource, oRegWrite,
                    oWBSel, oALUSrcA, oALUSrcB, oALUOp, oHalt};

    function automatic logic [15:0] ov(input int req, wr, iord, irw, pcw, pcs, rw,
                                       wb, sa, sb, op, h);
        return {1'(req), 1'(wr), 1'(iord), 1'(irw), 1'(pcw), 1'(pcs), 1'(rw),
                2'(wb), 2'(sa), 2'(sb), 2'(op), 1'(h)};
    endfunction

    logic [15:0] F_WAIT, F_GO, DEC, WBA, ADR, MRD, MWR, HLT;

    typedef struct packed {
        logic        rdy;
        logic [15:0] o;
    } rec_t;
    rec_t q[$];

    longint unsigned m_cyc, m_ins;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    function automatic logic [63:0] e_cyc();
`ifdef MC_PERF_COUNTERS_EN
        return m_cyc;
`else
        return 64'd0;
`endif
    endfunction

    function automatic logic [63:0] e_ins();
`ifdef MC_PERF_COUNTERS_EN
        return m_ins;
`else
        return 64'd0;
`endif
    endfunction

    task automatic push(input logic [15:0] o, input logic rdy);
        rec_t r;
        r.rdy = rdy;
        r.o   = o;
        q.push_back(r);
    endtask

    // States that ignore iMemReady receive a random value for it.
    task automatic pushx(input logic [15:0] o);
        push(o, 1'($urandom_range(0, 1)));
    endtask

    // Reference model: the per-cycle output timeline of one instruction,
    // with fw wait cycles in fetch and mw wait cycles in the data access.
    task automatic build(input logic [6:0] op, input logic [2:0] f3,
                         input logic z, lt, ltu, input int fw, mw);
        logic taken, valid;
        q.delete();
        for (int i = 0; i < fw; i++) push(F_WAIT, 1'b0);
        push(F_GO, 1'b1);
        pushx(DEC);
        case (op)
            7'h33: begin pushx(ov(0,0,0,0,0,0,0,0,2,0,2,0)); pushx(WBA); end
            7'h13: begin pushx(ov(0,0,0,0,0,0,0,0,2,2,2,0)); pushx(WBA); end
            7'h37: begin pushx(ov(0,0,0,0,0,0,0,0,3,2,0,0)); pushx(WBA); end
            7'h17: begin pushx(ov(0,0,0,0,0,0,0,0,1,2,0,0)); pushx(WBA); end
            7'h03: begin
                pushx(ADR);
                for (int i = 0; i < mw; i++) push(MRD, 1'b0);
                push(MRD, 1'b1);
                pushx(ov(0,0,0,0,0,0,1,1,0,0,0,0));
            end
            7'h23: begin
                pushx(ADR);
                for (int i = 0; i < mw; i++) push(MWR, 1'b0);
                push(MWR, 1'b1);
            end
            7'h63: begin
                valid = (f3 != 3'd2) && (f3 != 3'd3);
                case (f3)
                    3'd0: taken = z;
                    3'd1: taken = !z;
                    3'd4: taken = lt;
                    3'd5: taken = !lt;
                    3'd6: taken = ltu;
                    3'd7: taken = !ltu;
                    default: taken = 1'b0;
                endcase
                pushx(ov(0,0,0,0,int'(taken && valid),1,0,0,2,0,1,0));
                if (!valid) pushx(HLT);
            end
            7'h6F: pushx(ov(0,0,0,0,1,1,1,2,0,0,0,0));
            7'h67: pushx(ov(0,0,0,0,1,0,1,2,2,2,0,0));
            default: pushx(HLT);
        endcase
    endtask

    // Entered and left at posedge+1. Checks each cycle, then one extra cycle
    // that must show FETCH (or HALT) and the counters.
    task automatic run_instr(input logic [6:0] op, input logic [2:0] f3,
                             input logic z, lt, ltu, input int fw, mw,
                             output int n_req, n_pcw, n_rw, output logic halted);
        build(op, f3, z, lt, ltu, fw, mw);
        iOpcode = op; iFunct3 = f3; iZero = z; iLt = lt; iLtu = ltu;
        iFunct7b5 = 1'($urandom_range(0, 1));
        n_req = 0; n_pcw = 0; n_rw = 0;
        foreach (q[i]) begin
            iMemReady = q[i].rdy;
            @(negedge clock);
            chk($sformatf("op%h_f%0d_cyc%0d", op, f3, i), 64'(dut_o), 64'(q[i].o));
            n_req += int'(oMemReq);
            n_pcw += int'(oPCWrite);
            n_rw  += int'(oRegWrite);
            @(posedge clock); #1;
            if (!q[i].o[0]) m_cyc++;
        end
        halted = q[q.size()-1].o[0];
        if (!halted) m_ins++;
        iMemReady = 1'b0;
        @(negedge clock);
        chk($sformatf("op%h_next", op), 64'(dut_o), 64'(halted ? HLT : F_WAIT));
        chk("cycle_count", oCycleCount, e_cyc());
        chk("instret", oInstret, e_ins());
        @(posedge clock); #1;
        if (!halted) m_cyc++;
    endtask

    // Leaves the DUT one cycle into FETCH at posedge+1.
    task automatic do_reset();
        reset = 1'b1;
        iMemReady = 1'b0;
        iOpcode = 7'($urandom); iFunct3 = 3'($urandom);
        iZero = 1'b1; iLt = 1'b1; iLtu = 1'b1; iFunct7b5 = 1'b0;
        #1;
        chk("reset_outputs", 64'(dut_o), 64'd0);
        chk("reset_counters", oCycleCount | oInstret, 64'd0);
        repeat (2) @(posedge clock);
        @(negedge clock);
        reset = 1'b0;
        m_cyc = 0; m_ins = 0;
        @(posedge clock); #1;
        m_cyc++;
    endtask

    typedef struct packed {
        logic [6:0] op;
        logic [2:0] f3;
        logic       z, lt, ltu;
        int         fw, mw, e_req, e_pcw, e_rw;
        logic       e_halt;
    } vec_t;

    function automatic vec_t mkv(input logic [6:0] op, input logic [2:0] f3,
                                 input logic z, lt, ltu, input int fw, mw, rq, pw, rw,
                                 input logic h);
        vec_t v;
        v.op = op; v.f3 = f3; v.z = z; v.lt = lt; v.ltu = ltu;
        v.fw = fw; v.mw = mw; v.e_req = rq; v.e_pcw = pw; v.e_rw = rw; v.e_halt = h;
        return v;
    endfunction

    vec_t tbl[17];
    logic [6:0] ops[10];

    initial begin
        int   n_req, n_pcw, n_rw;
        logic halted;

        F_WAIT = ov(1,0,0,0,0,0,0,0,0,1,0,0);
        F_GO   = ov(1,0,0,1,1,0,0,0,0,1,0,0);
        DEC    = ov(0,0,0,0,0,0,0,0,1,2,0,0);
        WBA    = ov(0,0,0,0,0,0,1,0,0,0,0,0);
        ADR    = ov(0,0,0,0,0,0,0,0,2,2,0,0);
        MRD    = ov(1,0,1,0,0,0,0,0,0,0,0,0);
        MWR    = ov(1,1,1,0,0,0,0,0,0,0,0,0);
        HLT    = ov(0,0,0,0,0,0,0,0,0,0,0,1);

        //           op     f3    z  lt ltu fw mw req pcw rw halt
        tbl[0]  = mkv(7'h33, 3'd0, 0, 0, 0, 0, 0, 1, 1, 1, 0); // add
        tbl[1]  = mkv(7'h03, 3'd2, 0, 0, 0, 0, 3, 5, 1, 1, 0); // lw, 3 waits
        tbl[2]  = mkv(7'h23, 3'd2, 0, 0, 0, 1, 1, 4, 1, 0, 0); // sw
        tbl[3]  = mkv(7'h63, 3'd0, 1, 0, 0, 0, 0, 1, 2, 0, 0); // beq taken
        tbl[4]  = mkv(7'h63, 3'd0, 0, 1, 1, 0, 0, 1, 1, 0, 0); // beq not taken
        tbl[5]  = mkv(7'h63, 3'd6, 0, 0, 1, 0, 0, 1, 2, 0, 0); // bltu taken
        tbl[6]  = mkv(7'h63, 3'd5, 0, 1, 0, 0, 0, 1, 1, 0, 0); // bge not taken
        tbl[7]  = mkv(7'h63, 3'd1, 0, 0, 0, 0, 0, 1, 2, 0, 0); // bne taken
        tbl[8]  = mkv(7'h6F, 3'd0, 0, 0, 0, 0, 0, 1, 2, 1, 0); // jal
        tbl[9]  = mkv(7'h67, 3'd0, 0, 0, 0, 0, 0, 1, 2, 1, 0); // jalr
        tbl[10] = mkv(7'h37, 3'd0, 0, 0, 0, 2, 0, 3, 1, 1, 0); // lui, fetch waits
        tbl[11] = mkv(7'h17, 3'd0, 0, 0, 0, 0, 0, 1, 1, 1, 0); // auipc
        tbl[12] = mkv(7'h13, 3'd0, 0, 0, 0, 0, 2, 1, 1, 1, 0); // addi
        tbl[13] = mkv(7'h03, 3'd2, 0, 0, 0, 0, 0, 2, 1, 1, 0); // lw, no waits
        tbl[14] = mkv(7'h7F, 3'd0, 0, 0, 0, 0, 0, 1, 1, 0, 1); // illegal opcode
        tbl[15] = mkv(7'h63, 3'd2, 1, 1, 1, 0, 0, 1, 1, 0, 1); // bad branch funct3
        tbl[16] = mkv(7'h73, 3'd0, 0, 0, 0, 0, 0, 1, 1, 0, 1); // system

        do_reset();

        // Reset asserted in the middle of a stalled load.
        build(7'h03, 3'd2, 0, 0, 0, 0, 5);
        iOpcode = 7'h03; iFunct3 = 3'd2;
        for (int i = 0; i < 4; i++) begin
            iMemReady = q[i].rdy;
            @(negedge clock);
            chk($sformatf("pre_reset_cyc%0d", i), 64'(dut_o), 64'(q[i].o));
            if (i < 3) begin @(posedge clock); #1; end
        end
        #2 reset = 1'b1;
        #1 chk("async_reset_outputs", 64'(dut_o), 64'd0);
        do_reset();
        iMemReady = 1'b0;
        @(negedge clock);
        chk("recover_fetch", 64'(dut_o), 64'(F_WAIT));
        @(posedge clock); #1;
        m_cyc++;

        // Directed table.
        foreach (tbl[k]) begin
            run_instr(tbl[k].op, tbl[k].f3, tbl[k].z, tbl[k].lt, tbl[k].ltu,
                      tbl[k].fw, tbl[k].mw, n_req, n_pcw, n_rw, halted);
            chk($sformatf("t%0d_req_cycles", k), 64'(n_req), 64'(tbl[k].e_req));
            chk($sformatf("t%0d_pcwrites", k), 64'(n_pcw), 64'(tbl[k].e_pcw));
            chk($sformatf("t%0d_regwrites", k), 64'(n_rw), 64'(tbl[k].e_rw));
            chk($sformatf("t%0d_halted", k), 64'(halted), 64'(tbl[k].e_halt));
            if (halted) begin
                // HALT is sticky: no strobes and frozen counters whatever the inputs.
                for (int c = 0; c < 20; c++) begin
                    iOpcode = 7'($urandom); iFunct3 = 3'($urandom);
                    iMemReady = 1'($urandom); iZero = 1'($urandom);
                    @(negedge clock);
                    chk($sformatf("t%0d_halt_hold%0d", k, c), 64'(dut_o), 64'(HLT));
                    chk("halt_cycle_count", oCycleCount, e_cyc());
                    @(posedge clock); #1;
                end
                do_reset();
            end
        end

        // Random instruction stream against the reference model.
        ops = '{7'h33, 7'h13, 7'h03, 7'h23, 7'h63, 7'h6F, 7'h67, 7'h37, 7'h17, 7'h63};
        for (int n = 0; n < 200; n++) begin
            logic [6:0] op;
            op = ($urandom_range(0, 19) == 0) ? 7'($urandom) : ops[$urandom_range(0, 9)];
            run_instr(op, 3'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
                      $urandom_range(0, 3), $urandom_range(0, 3), n_req, n_pcw, n_rw, halted);
            if (halted) do_reset();
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/multicycle_control.md
Name: multicycle_control

Overview:
- Control FSM that sequences the multicycle RV32I datapath instantiated under TopDE: fetch, decode, execute, memory access and writeback.
- Drives every datapath strobe and mux select from the registered state.
- Stalls on a shared instruction/data memory ready handshake.
- Decides conditional branches from ALU flags.

Parameters:
- RESET_HALT, 0, 1 = power up in HALT instead of FETCH (debug bring-up).

Ports:
- clock  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- iOpcode  input  7  IR[6:0].
- iFunct3  input  3  IR[14:12].
- iFunct7b5  input  1  IR[30].
- iZero  input  1  ALU result == 0.
- iLt  input  1  signed rs1<rs2.
- iLtu  input  1  unsigned rs1<rs2.
- iMemReady  input  1  memory completes the current request this cycle.
- oMemReq  output  1  memory access request.
- oMemWrite  output  1  request is a store.
- oIorD  output  1  0 = PC address, 1 = ALUOut address.
- oIRWrite  output  1  latch instruction register and OldPC.
- oPCWrite  output  1  load PC.
- oPCSource  output  1  0 = ALU result, 1 = ALUOut.
- oRegWrite  output  1  register file write.
- oWBSel  output  2  0 = ALUOut, 1 = MDR, 2 = PC (PC+4 link).
- oALUSrcA  output  2  0 = PC, 1 = OldPC, 2 = rs1, 3 = zero.
- oALUSrcB  output  2  0 = rs2, 1 = const 4, 2 = imm.
- oALUOp  output  2  0 = add, 1 = sub, 2 = decode funct3/funct7.
- oHalt  output  1  FSM in HALT.
- oCycleCount  output  64  see Optional Feature.
- oInstret  output  64  see Optional Feature.

Behaviour:
- Reset (async): state <= FETCH, or HALT when RESET_HALT=1. While reset is high, every output is 0.
- Outputs are a pure decode of the current state plus iMemReady/flags. The only registered element is the state.
- FETCH:
  - oMemReq=1, IorD=0, SrcA=PC, SrcB=4, ALUOp=add, PCSource=0.
  - oIRWrite = oPCWrite = iMemReady.
  - Hold until iMemReady, then go to DECODE.
- DECODE:
  - SrcA=OldPC, SrcB=imm, add, so ALUOut = branch/JAL target.
  - Next state by opcode:
    - 0110011 -> EXEC_R
    - 0010011 -> EXEC_I
    - 0000011 / 0100011 -> ADDR
    - 1100011 -> BRANCH
    - 1101111 -> JAL
    - 1100111 -> JALR
    - 0110111 -> EXEC_LUI
    - 0010111 -> EXEC_AUIPC
    - 1110011 -> HALT
    - any other opcode -> HALT
- EXEC_R: SrcA=rs1, SrcB=rs2, ALUOp=2. Next WB_ALU.
- EXEC_I: SrcA=rs1, SrcB=imm, ALUOp=2. Next WB_ALU.
- EXEC_LUI: SrcA=zero, SrcB=imm, add. Next WB_ALU.
- EXEC_AUIPC: SrcA=OldPC, SrcB=imm, add. Next WB_ALU.
- WB_ALU: RegWrite=1, WBSel=0. Next FETCH.
- ADDR: SrcA=rs1, SrcB=imm, add. Next MEM_RD for a load, MEM_WR for a store.
- MEM_RD: oMemReq=1, IorD=1. Hold until iMemReady, then WB_MEM.
- WB_MEM: RegWrite=1, WBSel=1. Next FETCH.
- MEM_WR: oMemReq=1, oMemWrite=1, IorD=1. Hold until iMemReady, then FETCH.
- BRANCH:
  - SrcA=rs1, SrcB=rs2, sub, PCSource=1.
  - taken by funct3: 000 = iZero, 001 = !iZero, 100 = iLt, 101 = !iLt, 110 = iLtu, 111 = !iLtu.
  - oPCWrite = taken. Next FETCH.
  - funct3 010 or 011 -> HALT, with no PC write.
- JAL: RegWrite=1, WBSel=2, PCWrite=1, PCSource=1. Next FETCH.
- JALR: SrcA=rs1, SrcB=imm, add, PCSource=0, PCWrite=1, RegWrite=1, WBSel=2. Next FETCH.
  - The datapath clears bit 0 of the target.
- HALT: oHalt=1, all strobes 0. Sticky until reset.
- Cycle counts with zero-wait memory:
  - R/I/LUI/AUIPC = 4, load = 5, store = 4, branch = 3, JAL/JALR = 3.
  - Each wait cycle on iMemReady adds 1.
- No strobe may be asserted for more than one cycle per state visit, except memory request hold.

Optional Feature:
- Macro: MC_PERF_COUNTERS_EN.
- Defined:
  - oCycleCount increments every cycle out of reset while not in HALT.
  - oInstret increments on every transition into FETCH from a non-FETCH state.
  - Both counters are 64-bit wrapping and reset to 0.
- Undefined: both ports exist and are driven constant 0, so TopDE wiring is unchanged.

Test Plan:
- Reset mid-MEM_RD with iMemReady=0 -> all outputs 0 immediately. After release, FETCH with oMemReq=1, IorD=0.
- add (0x002081B3), iMemReady always 1 -> states FETCH, DECODE, EXEC_R, WB_ALU. RegWrite=1 only in cycle 4; instret=1 at cycle 5.
- lw with iMemReady low for 3 cycles in MEM_RD -> oMemReq held 4 cycles, RegWrite with WBSel=1 one cycle later, total 8 cycles.
- beq, funct3=000: with iZero=1 -> oPCWrite=1, PCSource=1 in cycle 3. With iZero=0 -> oPCWrite=0. bltu with iLtu=1 -> taken.
- jal -> cycle 3 RegWrite=1, WBSel=2, PCWrite=1 together. jalr -> PCSource=0.
- Opcode 0x7F, or branch funct3=010 -> HALT, oHalt=1, no further strobes for 20 cycles, counters frozen. Reset recovers to FETCH.
